moving_sum_avg: RTL and testbench
=================================

Name: moving_sum_avg

Overview:
- Windowed moving sum and moving mean over the last 2**WIN_BITS valid samples of a signed stream.
- Sits in the moving-variance chain directly upstream of the signed DSP48 multiplier stage.
- Its mean output feeds both multiplier operands to form mean², and its dout_valid drives the multiplier's din_valid.
- Circular delay line in read-first block RAM, with an incremental accumulator: acc += new − oldest.

Parameters:
- DIN_WIDTH, 16, signed input sample width.
- WIN_BITS, 5, log2 of the window length (window = 32 samples).
- SUM_WIDTH, DIN_WIDTH+WIN_BITS, moving-sum width; sized so it can never overflow.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  DIN_WIDTH  signed sample.
- din_valid  input  1  sample qualifier; may be high every cycle, no backpressure.
- dout_sum  output  SUM_WIDTH  signed moving sum of the last min(n, 2**WIN_BITS) samples.
- dout_mean  output  DIN_WIDTH  dout_sum >>> WIN_BITS (arithmetic shift, floor toward −inf).
- dout_valid  output  1  one pulse per accepted sample.
- window_full  output  1  high once 2**WIN_BITS samples have been accepted since reset.

Behaviour:
- Reset (async assert, sync-safe deassert): every pipeline register, the accumulator, wr_ptr, fill_cnt, dout_sum, dout_mean, dout_valid and window_full go to 0. RAM contents are not cleared; they are masked by fill_cnt.
- Stage 1, on din_valid:
  - Write din to RAM[wr_ptr].
  - RAM returns the previous RAM[wr_ptr] (read-first, registered) as old.
  - Register din_r and v1.
  - Register mask1 = (fill_cnt == 2**WIN_BITS), evaluated before the increment.
  - wr_ptr increments modulo 2**WIN_BITS.
  - fill_cnt increments, saturating at 2**WIN_BITS.
- Stage 2: diff = din_r − (mask1 ? old : 0), width DIN_WIDTH+1, sign-extended; register diff and v2.
- Stage 3, on v2: acc <= acc + sign-extended diff; dout_sum <= same value; dout_mean <= that value >>> WIN_BITS; dout_valid <= 1. Otherwise dout_valid <= 0 and the data outputs hold.
- Latency: din_valid at edge k gives dout_valid at edge k+3, fixed. Throughput is 1 sample/cycle.
- Gaps: idle cycles change no state except valid bits; results are identical whether input is gapped or back-to-back.
- window_full is registered alongside stage 3. It rises together with the dout_valid of the 2**WIN_BITS-th sample and stays high until reset.
- Wrap-around: after the first full window, sample n subtracts sample n−2**WIN_BITS exactly, including across the wr_ptr wrap.
- Mid-operation reset: in-flight samples are discarded with no dout_valid. The post-reset window starts empty and stale RAM data must not appear in any sum.
- No overflow is possible: |sum| ≤ 2**WIN_BITS · 2**(DIN_WIDTH−1).

Decomposition:
- Shared package/include holds localparams WIN_LEN = 2**WIN_BITS and SUM_WIDTH_DEF, and a sign-extension helper macro reused by the variance chain.
- One sub-module, delay_ram_rf: single-port, read-first, registered-output RAM with parameters DATA_WIDTH and ADDR_WIDTH. It has no reset and is inferred as BRAM.

Test Plan:
- All tests below use WIN_BITS=2 (window 4), DIN_WIDTH=16.
- Reset check: hold rst_n=0 with din_valid=1 and din=7 → all outputs 0; then release.
- Constant 100 every cycle → dout_sum 100,200,300,400,400,…; dout_mean 25,50,75,100,100; window_full rises with the 4th output; dout_valid exactly 3 cycles after each input.
- Ramp 1..8 back-to-back → sums 1,3,6,10,14,18,22,26 (wrap subtraction correct).
- Negative/extreme inputs:
  - −3 ×4 → sums −3,−6,−9,−12 and means −1,−2,−3,−3 (floor).
  - −32768 ×6 → sum saturates at −131072 with no wrap.
- Gapped input: ramp 1..8 with din_valid high only every 3rd cycle → same sums as back-to-back; one dout_valid per input; no output change in gaps.
- Mid-stream reset: 6 samples of 100, pull rst_n low for 1 cycle with one sample in flight → no dout_valid for it. Then 50 ×5 → sums 50,100,150,200,200; window_full low until the 4th.

Source files
------------

// File: rtl/moving_sum_avg_pkg.sv
// moving_sum_avg_pkg
//   Shared constants for the moving-sum / moving-variance chain, plus a
//   sign-extension macro used by every stage that widens a signed value.
//   No ports.

`ifndef MOVING_SUM_AVG_PKG_SV
`define MOVING_SUM_AVG_PKG_SV

// Sign-extend 'val' (a plain identifier, from_w bits wide) to to_w bits.
// to_w must be strictly greater than from_w.
`define MSA_SEXT(val, from_w, to_w) {{((to_w)-(from_w)){val[(from_w)-1]}}, val}

package moving_sum_avg_pkg;

  localparam int DIN_WIDTH_DEF = 16;
  localparam int WIN_BITS_DEF  = 5;
  localparam int WIN_LEN       = 2**WIN_BITS_DEF;
  // One extra bit per doubling of the window covers the worst case of
  // WIN_LEN samples all at full scale.
  localparam int SUM_WIDTH_DEF = DIN_WIDTH_DEF + WIN_BITS_DEF;

endpackage

`endif

// File: rtl/moving_sum_avg_delay_ram_rf.sv
// delay_ram_rf
//   Single-port, read-first RAM with a registered read port. When en is high,
//   rdata captures the word previously stored at addr while wdata replaces it.
//   No reset, so it maps onto block RAM.
// Ports:
//   clk    rising-edge clock
//   en     access enable (read old word and write new word)
//   addr   word address
//   wdata  write data
//   rdata  registered read data (old contents of addr)

module delay_ram_rf #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata     <= mem[addr];
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/moving_sum_avg.sv
// moving_sum_avg
//   Moving sum and moving mean over the last 2**WIN_BITS valid samples of a
//   signed stream. A circular delay line holds the window; the accumulator is
//   updated incrementally (acc += new - oldest). Three register stages:
//   RAM access, difference, accumulate.
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   din          signed input sample
//   din_valid    sample qualifier, may be high every cycle
//   dout_sum     signed sum of the last min(n, 2**WIN_BITS) samples
//   dout_mean    dout_sum >>> WIN_BITS (floor toward -inf)
//   dout_valid   one pulse per accepted sample
//   window_full  high once a full window has been accepted since reset

module moving_sum_avg
  import moving_sum_avg_pkg::*;
#(
  parameter int DIN_WIDTH = DIN_WIDTH_DEF,
  parameter int WIN_BITS  = WIN_BITS_DEF,
  parameter int SUM_WIDTH = DIN_WIDTH + WIN_BITS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [DIN_WIDTH-1:0] din,
  input  logic                        din_valid,
  output logic signed [SUM_WIDTH-1:0] dout_sum,
  output logic signed [DIN_WIDTH-1:0] dout_mean,
  output logic                        dout_valid,
  output logic                        window_full
);

  localparam int                WIN_N     = 2**WIN_BITS;
  localparam logic [WIN_BITS:0] FILL_MAX  = (WIN_BITS+1)'(WIN_N);
  localparam logic [WIN_BITS:0] FILL_LAST = (WIN_BITS+1)'(WIN_N - 1);
  localparam logic [WIN_BITS:0] FILL_ONE  = (WIN_BITS+1)'(1);
  localparam logic [WIN_BITS-1:0] PTR_ONE = WIN_BITS'(1);

  // stage 1
  logic [WIN_BITS-1:0]         wr_ptr;
  logic [WIN_BITS:0]           fill_cnt;
  logic signed [DIN_WIDTH-1:0] din_r;
  logic signed [DIN_WIDTH-1:0] old;
  logic                        v1;
  logic                        mask1;
  logic                        full1;

  // stage 2
  logic signed [DIN_WIDTH:0]   din_x;
  logic signed [DIN_WIDTH:0]   old_x;
  logic signed [DIN_WIDTH:0]   diff;
  logic                        v2;
  logic                        full2;

  // stage 3
  logic signed [SUM_WIDTH-1:0] diff_x;
  logic signed [SUM_WIDTH-1:0] sum_next;
  logic signed [SUM_WIDTH-1:0] acc;

  delay_ram_rf #(
    .DATA_WIDTH (DIN_WIDTH),
    .ADDR_WIDTH (WIN_BITS)
  ) u_ram (
    .clk   (clk),
    .en    (din_valid),
    .addr  (wr_ptr),
    .wdata (din),
    .rdata (old)
  );

  // RAM words are never cleared; mask1 keeps stale contents out of the sum
  // until the slot being overwritten was written since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      din_r    <= '0;
      v1       <= 1'b0;
      mask1    <= 1'b0;
      full1    <= 1'b0;
    end else begin
      v1 <= din_valid;
      if (din_valid) begin
        din_r  <= din;
        mask1  <= (fill_cnt == FILL_MAX);
        full1  <= (fill_cnt >= FILL_LAST);
        wr_ptr <= wr_ptr + PTR_ONE;
        if (fill_cnt != FILL_MAX)
          fill_cnt <= fill_cnt + FILL_ONE;
      end
    end
  end

  always_comb begin
    din_x = `MSA_SEXT(din_r, DIN_WIDTH, DIN_WIDTH+1);
    old_x = '0;
    if (mask1)
      old_x = `MSA_SEXT(old, DIN_WIDTH, DIN_WIDTH+1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff  <= '0;
      v2    <= 1'b0;
      full2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        diff  <= din_x - old_x;
        full2 <= full1;
      end
    end
  end

  always_comb begin
    diff_x   = `MSA_SEXT(diff, DIN_WIDTH+1, SUM_WIDTH);
    sum_next = acc + diff_x;
  end

  // The top DIN_WIDTH bits of the sum are exactly sum >>> WIN_BITS, and the
  // sum's range guarantees the mean fits DIN_WIDTH bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      dout_mean   <= '0;
      dout_valid  <= 1'b0;
      window_full <= 1'b0;
    end else begin
      dout_valid <= v2;
      if (v2) begin
        acc       <= sum_next;
        dout_mean <= sum_next[SUM_WIDTH-1:WIN_BITS];
        if (full2)
          window_full <= 1'b1;
      end
    end
  end

  assign dout_sum = acc;

endmodule

// File: tb/tb_moving_sum_avg.sv
module tb_moving_sum_avg;

  localparam int DW = 16;
  localparam int WB = 2;
  localparam int SW = DW + WB;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic signed [DW-1:0] din = '0;
  logic                 din_valid = 1'b0;
  logic signed [SW-1:0] dout_sum;
  logic signed [DW-1:0] dout_mean;
  logic                 dout_valid;
  logic                 window_full;

  moving_sum_avg #(
    .DIN_WIDTH (DW),
    .WIN_BITS  (WB),
    .SUM_WIDTH (SW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .dout_sum    (dout_sum),
    .dout_mean   (dout_mean),
    .dout_valid  (dout_valid),
    .window_full (window_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int din;
    int sum;
    int mean;
    int full;
  } vec_t;

  vec_t vecs[29];

  int n_applied = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int prev_sum  = 0;
  int prev_mean = 0;
  int prev_full = 0;
  int due_q[$];
  int idx_q[$];

  function automatic void setv(int i, int d, int s, int m, int f);
    vecs[i].din  = d;
    vecs[i].sum  = s;
    vecs[i].mean = m;
    vecs[i].full = f;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_applied++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    due_q.delete();
    idx_q.delete();
    prev_sum  = 0;
    prev_mean = 0;
    prev_full = 0;
  endtask

  // One cycle: sample outputs at the falling edge and compare against the
  // expected result due this cycle, or against the held values otherwise.
  task automatic tick_check();
    int idx;
    @(negedge clk);
    cyc++;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      idx = idx_q.pop_front();
      void'(due_q.pop_front());
      chk("valid", int'(dout_valid), 1);
      chk("sum",   int'(dout_sum),   vecs[idx].sum);
      chk("mean",  int'(dout_mean),  vecs[idx].mean);
      chk("full",  int'(window_full), vecs[idx].full);
      prev_sum  = vecs[idx].sum;
      prev_mean = vecs[idx].mean;
      prev_full = vecs[idx].full;
    end else begin
      chk("idle_valid", int'(dout_valid), 0);
      chk("hold_sum",   int'(dout_sum),   prev_sum);
      chk("hold_mean",  int'(dout_mean),  prev_mean);
      chk("hold_full",  int'(window_full), prev_full);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    din_valid = 1'b1;
    din       = 16'sd7;
    repeat (3) @(negedge clk);
    chk("rst_sum",   int'(dout_sum),    0);
    chk("rst_mean",  int'(dout_mean),   0);
    chk("rst_valid", int'(dout_valid),  0);
    chk("rst_full",  int'(window_full), 0);
    din_valid = 1'b0;
    din       = '0;
    rst_n     = 1'b1;
    clear_model();
  endtask

  // Feed vecs[first .. first+n-1] with 'gap' idle cycles between samples.
  // A sample driven after falling edge c is taken at rising edge c+1 and
  // must appear at the falling edge three cycles later.
  task automatic run(input int first, input int n, input int gap);
    int issued = 0;
    int wait_cnt = 0;
    int budget = n * (gap + 1) + 10;
    for (int s = 0; s < budget && (issued < n || due_q.size() > 0); s++) begin
      tick_check();
      if (issued < n && wait_cnt == 0) begin
        din       = DW'(vecs[first + issued].din);
        din_valid = 1'b1;
        due_q.push_back(cyc + 3);
        idx_q.push_back(first + issued);
        issued++;
        wait_cnt = gap;
      end else begin
        din_valid = 1'b0;
        if (wait_cnt > 0) wait_cnt--;
      end
    end
    din_valid = 1'b0;
    chk("drain", due_q.size() + (n - issued), 0);
  endtask

  initial begin
    // constant 100
    for (int i = 0; i < 6; i++)
      setv(i, 100, (i < 4) ? 100 * (i + 1) : 400, (i < 4) ? 25 * (i + 1) : 100, (i >= 3) ? 1 : 0);
    // ramp 1..8
    setv(6,  1,  1, 0, 0);
    setv(7,  2,  3, 0, 0);
    setv(8,  3,  6, 1, 0);
    setv(9,  4, 10, 2, 1);
    setv(10, 5, 14, 3, 1);
    setv(11, 6, 18, 4, 1);
    setv(12, 7, 22, 5, 1);
    setv(13, 8, 26, 6, 1);
    // -3 x4
    setv(14, -3,  -3, -1, 0);
    setv(15, -3,  -6, -2, 0);
    setv(16, -3,  -9, -3, 0);
    setv(17, -3, -12, -3, 1);
    // full-scale negative x6
    setv(18, -32768,  -32768,  -8192, 0);
    setv(19, -32768,  -65536, -16384, 0);
    setv(20, -32768,  -98304, -24576, 0);
    setv(21, -32768, -131072, -32768, 1);
    setv(22, -32768, -131072, -32768, 1);
    setv(23, -32768, -131072, -32768, 1);
    // 50 x5 after a mid-stream reset
    setv(24, 50,  50, 12, 0);
    setv(25, 50, 100, 25, 0);
    setv(26, 50, 150, 37, 0);
    setv(27, 50, 200, 50, 1);
    setv(28, 50, 200, 50, 1);

    do_reset();
    run(0, 6, 0);

    do_reset();
    run(6, 8, 0);

    do_reset();
    run(6, 8, 2);

    do_reset();
    run(14, 4, 0);

    do_reset();
    run(18, 6, 0);

    // mid-stream reset with one sample in flight
    do_reset();
    run(0, 6, 0);
    tick_check();
    din       = 16'sd100;
    din_valid = 1'b1;
    tick_check();
    din_valid = 1'b0;
    rst_n     = 1'b0;
    clear_model();
    tick_check();
    rst_n = 1'b1;
    repeat (4) tick_check();
    run(24, 5, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule
